// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: Diff = A - B - Bin, computed CHUNK bits per cycle
// with the borrow carried in a register, behind valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         busy
);

    localparam int M  = N / CHUNK;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             borrow_q;
    logic [KW-1:0]    k_q;

    int unsigned      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;

    // Subtraction as A + ~B + ~borrow; the carry out of each chunk is the inverted borrow.
    always_comb begin
        base    = int'(k_q) * CHUNK;
        a_chunk = a_q[base +: CHUNK];
        b_chunk = b_q[base +: CHUNK];
        sum     = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, ~borrow_q};
    end

    // NOTE: state is updated with non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            borrow_q  <= 1'b0;
            k_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        Diff     <= '0;
                        k_q      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    Diff[base +: CHUNK] <= sum[CHUNK-1:0];
                    borrow_q            <= ~sum[CHUNK];
                    if (k_q == K_LAST) begin
                        Bout      <= ~sum[CHUNK];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at N=8/CHUNK=4 (M=2) and N=64/CHUNK=64 (M=1).
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid0, in_ready0, Bin0, out_valid0, out_ready0, Bout0, busy0;
    logic [7:0]  A0, B0, Diff0;
    logic        in_valid1, in_ready1, Bin1, out_valid1, out_ready1, Bout1, busy1;
    logic [63:0] A1, B1, Diff1;

    serial_subtractor #(.N(8), .CHUNK(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .A(A0), .B(B0), .Bin(Bin0), .out_valid(out_valid0), .out_ready(out_ready0),
        .Diff(Diff0), .Bout(Bout0), .busy(busy0)
    );

    serial_subtractor #(.N(64), .CHUNK(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(A1), .B(B1), .Bin(Bin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .Diff(Diff1), .Bout(Bout1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Present operands, wait for the accepting edge, then count edges until out_valid.
    task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic bin, output int lat);
        int n;
        @(negedge clk);
        A0 = a; B0 = b; Bin0 = bin; in_valid0 = 1'b1;
        n = 0;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait8", n < 50, 1);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        check("busy_after_accept8", busy0, 1);
        check("in_ready_after_accept8", in_ready0, 0);
        lat = 0;
        while (!out_valid0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic send1(input logic [63:0] a, input logic [63:0] b, input logic bin, output int lat);
        int n;
        @(negedge clk);
        A1 = a; B1 = b; Bin1 = bin; in_valid1 = 1'b1;
        n = 0;
        while (!in_ready1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait64", n < 50, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain0(input int stall);
        repeat (stall) @(negedge clk);
        @(negedge clk);
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        check("release_out_valid8", out_valid0, 0);
        check("release_in_ready8", in_ready0, 1);
    endtask

    task automatic drain1(input int stall);
        repeat (stall) @(negedge clk);
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("release_out_valid64", out_valid1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        int          lat;
        logic        seen;
        logic [8:0]  g8;
        logic [64:0] g64;
        logic [7:0]  ra, rb;
        logic [63:0] wa, wb;
        logic        rbin;

        vecs[0] = '{8'h0F, 8'h05, 1'b0, 8'h0A, 1'b0};
        vecs[1] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0};
        vecs[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{8'h80, 8'h81, 1'b0, 8'hFF, 1'b1};
        vecs[7] = '{8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0};
        vecs[8] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1};
        vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        rst_n = 1'b0;
        in_valid0 = 1'b0; out_ready0 = 1'b0; A0 = '0; B0 = '0; Bin0 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; A1 = '0; B1 = '0; Bin1 = 1'b0;
        #12;
        check("reset_in_ready", in_ready0, 1);
        check("reset_out_valid", out_valid0, 0);
        check("reset_busy", busy0, 0);
        check("reset_diff", Diff0, 0);
        check("reset_bout", Bout0, 0);
        check("reset_in_ready64", in_ready1, 1);
        @(negedge clk);
        rst_n = 1'b1;

        send0(8'h0F, 8'h05, 1'b0, lat);
        check("latency_m2", lat, 2);
        check("basic_diff", Diff0, 8'h0A);
        check("basic_bout", Bout0, 0);
        drain0(0);

        for (int i = 0; i < 10; i++) begin
            send0(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            check($sformatf("vec%0d_latency", i), lat, 2);
            check($sformatf("vec%0d_diff", i), Diff0, vecs[i].diff);
            check($sformatf("vec%0d_bout", i), Bout0, vecs[i].bout);
            drain0(i % 3);
        end

        // Back-pressure: result must hold while new operands are waved at the input.
        send0(8'h5A, 8'h3C, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A0 = A0 + 8'h11; B0 = B0 ^ 8'hA5;
            in_valid0 = (i == 2);
            check("stall_diff", Diff0, 8'h1E);
            check("stall_bout", Bout0, 0);
            check("stall_in_ready", in_ready0, 0);
            check("stall_out_valid", out_valid0, 1);
        end
        @(negedge clk);
        in_valid0 = 1'b0;
        drain0(0);
        repeat (2) @(posedge clk);
        #1;
        check("stall_no_reaccept_busy", busy0, 0);
        check("stall_no_reaccept_valid", out_valid0, 0);

        // Reset in the first RUN cycle discards the operation.
        @(negedge clk);
        A0 = 8'h77; B0 = 8'h11; Bin0 = 1'b0; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        check("midop_busy_before_reset", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("midop_reset_in_ready", in_ready0, 1);
        check("midop_reset_out_valid", out_valid0, 0);
        check("midop_reset_busy", busy0, 0);
        check("midop_reset_diff", Diff0, 0);
        check("midop_reset_bout", Bout0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | out_valid0;
        end
        check("midop_no_result", seen, 0);
        send0(8'd3, 8'd1, 1'b0, lat);
        check("after_reset_diff", Diff0, 8'd2);
        check("after_reset_bout", Bout0, 0);
        drain0(1);

        // Single-chunk instance: result on the edge right after acceptance.
        send1(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat);
        check("m1_latency", lat, 1);
        check("m1_wrap_diff", Diff1, 64'h0);
        check("m1_wrap_bout", Bout1, 1);
        drain1(0);
        send1(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, lat);
        check("m1_equal_diff", Diff1, 64'h0);
        check("m1_equal_bout", Bout1, 0);
        drain1(2);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            g8 = {1'b0, ra} + {1'b0, ~rb} + {8'b0, ~rbin};
            send0(ra, rb, rbin, lat);
            total++;
            if (Diff0 !== g8[7:0] || Bout0 !== ~g8[8] || lat != 2) begin
                bad++;
                $display("FAIL rand8: A=%h B=%h Bin=%b got=%b_%h lat=%0d expected=%b_%h lat=2",
                         ra, rb, rbin, Bout0, Diff0, lat, ~g8[8], g8[7:0]);
                break;
            end
            drain0($urandom_range(0, 3));
        end

        for (int i = 0; i < 20; i++) begin
            wa = {$urandom, $urandom}; wb = {$urandom, $urandom}; rbin = 1'($urandom);
            g64 = {1'b0, wa} + {1'b0, ~wb} + {64'b0, ~rbin};
            send1(wa, wb, rbin, lat);
            total++;
            if (Diff1 !== g64[63:0] || Bout1 !== ~g64[64] || lat != 1) begin
                bad++;
                $display("FAIL rand64: A=%h B=%h Bin=%b got=%b_%h lat=%0d expected=%b_%h lat=1",
                         wa, wb, rbin, Bout1, Diff1, lat, ~g64[64], g64[63:0]);
                break;
            end
            drain1($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
